// File: rtl/serial_addsub_if.sv
// serial_addsub handshake/operand bundle.
// master drives requests, slave returns results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first,
// one parity cell, one majority cell, one carry FF.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_sbit;
  logic             w_cnxt;
  logic [WIDTH-1:0] w_part_nxt;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = bus.start && !w_run;
  assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

  assign w_sbit = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cnxt = (r_a[0] & r_b[0])
                | (r_a[0] & r_carry)
                | (r_b[0] & r_carry);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_part_nxt = w_sbit;
    end else begin : g_wn
      assign w_part_nxt = {w_sbit, r_part[WIDTH-1:1]};
    end
  endgenerate

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state: accept in IDLE/DONE, finish after WIDTH bits
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand load, serial step, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.c_in;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cnxt;
      r_part  <= w_part_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // r_carry here is the carry into the MSB
        r_sum  <= w_part_nxt;
        r_cout <= w_cnxt;
        r_ovf  <= r_carry ^ w_cnxt;
      end
    end
  end

  assign bus.busy     = w_run;
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.c_out    = r_cout;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub,
// WIDTH=8 and WIDTH=1 instances.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) b8();
  serial_addsub_if #(.WIDTH(1)) b1();

  serial_addsub #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b8)
  );

  serial_addsub #(.WIDTH(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] p_s;
  logic       p_c;
  logic       p_v;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        v;
  } res_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Arithmetic reference: integer sum/difference,
  // signed range test for overflow.
  function automatic res_t model(
    input int              w,
    input logic            sb,
    input longint unsigned a,
    input longint unsigned b,
    input logic            cin);
    res_t            r;
    longint unsigned m, u;
    longint          sa, sv, t, lo, hi;
    m  = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w)
                : longint'(a);
    sv = b[w-1] ? longint'(b) - (longint'(1) << w)
                : longint'(b);
    if (sb) begin
      u = a + ((~b) & m) + 64'd1;
      t = sa - sv;
    end else begin
      u = a + b + longint'(cin);
      t = sa + sv + longint'(cin);
    end
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    r.s = u & m;
    r.c = u[w];
    r.v = (t > hi) || (t < lo);
    return r;
  endfunction

  task automatic issue8(input logic s,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic cin);
    b8.start = 1'b1;
    b8.sub   = s;
    b8.a     = a;
    b8.b     = b;
    b8.c_in  = cin;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b8.sub   = 1'($urandom);
    b8.a     = 8'($urandom);
    b8.b     = 8'($urandom);
    b8.c_in  = 1'($urandom);
  endtask

  task automatic op8(input string nm,
                     input logic s,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic cin,
                     input logic [7:0] es,
                     input logic ec,
                     input logic ev,
                     input bit bb);
    int lat;
    int bsy;
    issue8(s, a, b, cin);
    lat = 0;
    bsy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (b8.busy) bsy++;
      if (lat == 1)
        chk({nm, " hold"},
            {b8.sum, b8.c_out, b8.overflow},
            {p_s, p_c, p_v});
    end while (!b8.done && lat < 40);
    chk({nm, " sum"}, b8.sum, es);
    chk({nm, " c_out"}, b8.c_out, ec);
    chk({nm, " ovf"}, b8.overflow, ev);
    chk({nm, " latency"}, lat - 1, 8);
    chk({nm, " busy cycles"}, bsy, 8);
    chk({nm, " busy@done"}, b8.busy, 0);
    p_s = es;
    p_c = ec;
    p_v = ev;
    if (!bb) begin
      @(negedge clk);
      chk({nm, " done pulse"}, b8.done, 0);
    end
  endtask

  initial begin
    automatic int   nd;
    automatic int   lat;
    automatic res_t r;
    automatic logic rs;
    automatic logic [7:0] ra;
    automatic logic [7:0] rb;
    automatic logic rc;
    automatic logic a1;
    automatic logic bb1;
    automatic logic c1;

    tbl[0] = '{0, 8'h3C, 8'h05, 0, 8'h41, 0, 0};
    tbl[1] = '{0, 8'hFF, 8'h01, 1, 8'h01, 1, 0};
    tbl[2] = '{0, 8'h7F, 8'h01, 0, 8'h80, 0, 1};
    tbl[3] = '{1, 8'h10, 8'h20, 0, 8'hF0, 0, 0};
    tbl[4] = '{1, 8'h10, 8'h20, 1, 8'hF0, 0, 0};
    tbl[5] = '{1, 8'h80, 8'h01, 0, 8'h7F, 1, 1};
    tbl[6] = '{1, 8'h80, 8'h01, 1, 8'h7F, 1, 1};
    tbl[7] = '{0, 8'h00, 8'h00, 1, 8'h01, 0, 0};

    rst_n    = 1'b0;
    b8.start = 1'b0;
    b8.sub   = 1'b0;
    b8.a     = '0;
    b8.b     = '0;
    b8.c_in  = 1'b0;
    b1.start = 1'b0;
    b1.sub   = 1'b0;
    b1.a     = '0;
    b1.b     = '0;
    b1.c_in  = 1'b0;
    p_s = '0;
    p_c = 1'b0;
    p_v = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset w8",
        {b8.busy, b8.done, b8.sum, b8.c_out, b8.overflow},
        0);
    chk("reset w1",
        {b1.busy, b1.done, b1.sum, b1.c_out, b1.overflow},
        0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after reset", {b8.busy, b8.done}, 0);

    // WIDTH=1 exhaustive full-adder table
    for (int i = 0; i < 8; i++) begin
      c1  = i[2];
      a1  = i[1];
      bb1 = i[0];
      b1.start = 1'b1;
      b1.sub   = 1'b0;
      b1.a     = a1;
      b1.b     = bb1;
      b1.c_in  = c1;
      @(posedge clk);
      #1;
      b1.start = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!b1.done && lat < 10);
      chk($sformatf("w1 fa%0d latency", i), lat - 1, 1);
      chk($sformatf("w1 fa%0d sum", i), b1.sum,
          (32'(a1) + 32'(bb1) + 32'(c1)) % 2);
      chk($sformatf("w1 fa%0d c_out", i), b1.c_out,
          (32'(a1) + 32'(bb1) + 32'(c1)) / 2);
      @(negedge clk);
    end

    // WIDTH=1 random add/sub
    for (int i = 0; i < 8; i++) begin
      rs  = 1'($urandom);
      a1  = 1'($urandom);
      bb1 = 1'($urandom);
      c1  = 1'($urandom);
      r   = model(1, rs, 64'(a1), 64'(bb1), c1);
      b1.start = 1'b1;
      b1.sub   = rs;
      b1.a     = a1;
      b1.b     = bb1;
      b1.c_in  = c1;
      @(posedge clk);
      #1;
      b1.start = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!b1.done && lat < 10);
      chk("w1 rnd res",
          {b1.sum, b1.c_out, b1.overflow},
          {r.s[0], r.c, r.v});
      @(negedge clk);
    end

    // WIDTH=8 directed table
    foreach (tbl[i])
      op8($sformatf("tbl%0d", i), tbl[i].sub,
          tbl[i].a, tbl[i].b, tbl[i].cin,
          tbl[i].s, tbl[i].c, tbl[i].v, 0);

    // start held during RUN is ignored
    issue8(0, 8'h12, 8'h34, 0);
    b8.start = 1'b1;
    b8.sub   = 1'b1;
    b8.a     = 8'hFF;
    b8.b     = 8'hFF;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b8.done) begin
        nd++;
        b8.start = 1'b0;
        chk("ign sum", b8.sum, 8'h46);
        chk("ign flags", {b8.c_out, b8.overflow}, 0);
      end
    end
    chk("ign done count", nd, 1);
    p_s = 8'h46;
    p_c = 1'b0;
    p_v = 1'b0;

    // back-to-back: start in DONE cycle
    op8("bb1", 0, 8'h3C, 8'h05, 0, 8'h41, 0, 0, 1);
    op8("bb2", 1, 8'h80, 8'h01, 0, 8'h7F, 1, 1, 0);

    // reset in the middle of a run
    issue8(0, 8'h55, 8'h0F, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mid",
        {b8.busy, b8.done, b8.sum, b8.c_out, b8.overflow},
        0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (b8.done) nd++;
    end
    chk("rst no done", nd, 0);
    rst_n = 1'b1;
    p_s = '0;
    p_c = 1'b0;
    p_v = 1'b0;
    @(negedge clk);
    op8("post rst", 0, 8'h01, 8'h02, 0, 8'h03, 0, 0, 0);

    // random ops against the model
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      r  = model(8, rs, 64'(ra), 64'(rb), rc);
      op8($sformatf("rnd%0d", i), rs, ra, rb, rc,
          r.s[7:0], r.c, r.v, bit'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
